// File: rtl/ln_out_row_streamer.sv
// Captures one SEQ_LEN x EMB_DIM layer-norm result matrix and streams it row-major on valid/ready.
// Optional per-row sum output is enabled by defining LN_STREAM_ROW_SUM_EN.
//
// state    | meaning
// S_IDLE   | waiting for a matrix, in_ready high
// S_STREAM | presenting element (row,col) with m_valid high
// S_DONE   | final beat accepted, one-cycle done pulse
`timescale 1ns/1ps
module ln_out_row_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 8,
    parameter int EMB_DIM    = 8,
    localparam int ROW_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int COL_W     = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] in_data,
    input  logic                                  abort,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic [ROW_W-1:0]                      m_row,
    output logic [COL_W-1:0]                      m_col,
    output logic                                  m_last_col,
    output logic                                  m_last,
    output logic                                  done,
    output logic                                  busy
`ifdef LN_STREAM_ROW_SUM_EN
    ,
    output logic signed [DATA_WIDTH+$clog2(EMB_DIM):0] m_row_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [DATA_WIDTH-1:0] in_elem [SEQ_LEN][EMB_DIM];
    logic [DATA_WIDTH-1:0] mat_buf [SEQ_LEN][EMB_DIM];
    logic                  capture;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;

    // The bus carries rows in reverse order; unpack so mat_buf[r] is logical row r.
    for (genvar r = 0; r < SEQ_LEN; r++) begin : g_row
        for (genvar c = 0; c < EMB_DIM; c++) begin : g_col
            assign in_elem[r][c] = in_data[((SEQ_LEN-1-r)*EMB_DIM + c)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign capture  = (state == S_IDLE) && in_valid && !abort;
    assign accept   = m_valid && m_ready;
    assign last_col = (col == COL_W'(EMB_DIM-1));
    assign last_row = (row == ROW_W'(SEQ_LEN-1));

    // Buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            mat_buf <= in_elem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            m_valid <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            m_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        state   <= S_STREAM;
                        row     <= '0;
                        col     <= '0;
                        m_valid <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row     <= '0;
                                state   <= S_DONE;
                                m_valid <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    m_valid <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign busy       = !in_ready;
    assign m_row      = row;
    assign m_col      = col;
    assign m_data     = m_valid ? mat_buf[row][col] : '0;
    assign m_last_col = m_valid && last_col;
    assign m_last     = m_valid && last_col && last_row;

`ifdef LN_STREAM_ROW_SUM_EN
    localparam int SUM_W = DATA_WIDTH + $clog2(EMB_DIM) + 1;

    logic signed [SUM_W-1:0] row_acc;
    logic signed [SUM_W-1:0] elem_ext;

    assign elem_ext = SUM_W'($signed(m_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_acc <= '0;
        end else if (abort) begin
            row_acc <= '0;
        end else if (accept) begin
            row_acc <= last_col ? '0 : row_acc + elem_ext;
        end
    end

    // The last element of the row is folded in combinationally.
    assign m_row_sum = (m_valid && last_col) ? row_acc + elem_ext : '0;
`endif

endmodule
